// File: rtl/md_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package md_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    typedef enum logic {
        MD_OP_MULT = 1'b0,
        MD_OP_DIV  = 1'b1
    } md_op_t;

    localparam int          MD_ITER    = 32;
    localparam logic [31:0] MD_INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/md_iter_counter.sv
// Iteration counter for md_unit: 5-bit, synchronous clear, enable, flags the final iteration.
module md_iter_counter
    import md_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    logic [4:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 5'd1;
        end
    end

    assign last = (count == 5'(MD_ITER - 1));

endmodule

// File: rtl/md_unit.sv
// Iterative signed MULT/DIV unit: 32 shift-add / restoring shift-subtract steps on magnitudes.
// Optional build macro MD_EARLY_DIV0_EN completes divide-by-zero without iterating.
module md_unit
    import md_pkg::*;
#(
    parameter int MD_WIDTH = 32
) (
    input  logic                rise,
    input  logic                reset,
    input  logic [MD_WIDTH-1:0] operand_a,
    input  logic [MD_WIDTH-1:0] operand_b,
    input  logic                ctrl_mult,
    input  logic                ctrl_div,
    output logic [MD_WIDTH-1:0] result,
    output logic                md_ovf,
    output logic                result_rdy,
    output logic                busy
);

    md_state_t             state, state_nxt;
    md_op_t                op_r, start_op;
    logic                  neg_r;
    logic [MD_WIDTH-1:0]   opnd_r;
    logic [MD_WIDTH-1:0]   hi_r, lo_r;
    logic                  start, accept, early_div0, finish, last;

    logic [MD_WIDTH:0]     mult_sum;
    logic [MD_WIDTH-1:0]   mult_hi, mult_lo;
    logic [MD_WIDTH:0]     div_part, div_trial;
    logic [MD_WIDTH-1:0]   div_hi, div_lo;
    logic [MD_WIDTH-1:0]   step_hi, step_lo;
    logic [MD_WIDTH:0]     fixed;

    function automatic logic [MD_WIDTH-1:0] mag(input logic [MD_WIDTH-1:0] v);
        return v[MD_WIDTH-1] ? -v : v;
    endfunction

    // {ovf, result}: overflow when the upper half is not the sign extension of the lower.
    function automatic logic [MD_WIDTH:0] fix_mult(input logic [2*MD_WIDTH-1:0] pmag,
                                                   input logic neg);
        logic signed [2*MD_WIDTH-1:0] prod;
        prod = neg ? -$signed(pmag) : $signed(pmag);
        return {(prod[2*MD_WIDTH-1:MD_WIDTH] != {MD_WIDTH{prod[MD_WIDTH-1]}}),
                prod[MD_WIDTH-1:0]};
    endfunction

    // A positive quotient of magnitude INT_MIN only arises from INT_MIN / -1.
    function automatic logic [MD_WIDTH:0] fix_div(input logic [MD_WIDTH-1:0] qmag,
                                                  input logic neg,
                                                  input logic div0);
        logic signed [MD_WIDTH-1:0] quo;
        if (div0) begin
            return {1'b1, {MD_WIDTH{1'b0}}};
        end
        quo = neg ? -$signed(qmag) : $signed(qmag);
        return {(!neg && (qmag == MD_INT_MIN)), quo};
    endfunction

    assign start    = ctrl_mult | ctrl_div;
    assign start_op = ctrl_mult ? MD_OP_MULT : MD_OP_DIV;
    assign accept   = start && (state != MD_RUN);
    assign finish   = (state == MD_RUN) && last;

`ifdef MD_EARLY_DIV0_EN
    assign early_div0 = accept && !ctrl_mult && (operand_b == '0);
`else
    assign early_div0 = 1'b0;
`endif

    md_iter_counter u_iter_counter (
        .clk   (rise),
        .rst_n (reset),
        .clr   (accept),
        .en    (state == MD_RUN),
        .last  (last)
    );

    always_ff @(posedge rise or negedge reset) begin
        if (!reset) begin
            state <= MD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE, MD_DONE: begin
                if (accept) begin
                    state_nxt = early_div0 ? MD_DONE : MD_RUN;
                end else if (state == MD_DONE) begin
                    state_nxt = MD_IDLE;
                end
            end
            MD_RUN: begin
                if (last) begin
                    state_nxt = MD_DONE;
                end
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    // One iteration: hi_r is the product high half / partial remainder,
    // lo_r shifts out multiplier bits / dividend bits and shifts in quotient bits.
    always_comb begin
        mult_sum  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(MD_WIDTH+1){1'b0}});
        mult_hi   = mult_sum[MD_WIDTH:1];
        mult_lo   = {mult_sum[0], lo_r[MD_WIDTH-1:1]};
        div_part  = {hi_r, lo_r[MD_WIDTH-1]};
        div_trial = div_part - {1'b0, opnd_r};
        div_hi    = div_part[MD_WIDTH-1:0];
        div_lo    = {lo_r[MD_WIDTH-2:0], 1'b0};
        if (!div_trial[MD_WIDTH]) begin
            div_hi = div_trial[MD_WIDTH-1:0];
            div_lo = {lo_r[MD_WIDTH-2:0], 1'b1};
        end
        step_hi = (op_r == MD_OP_MULT) ? mult_hi : div_hi;
        step_lo = (op_r == MD_OP_MULT) ? mult_lo : div_lo;
        fixed   = (op_r == MD_OP_MULT) ? fix_mult({mult_hi, mult_lo}, neg_r)
                                       : fix_div(div_lo, neg_r, (opnd_r == '0));
    end

    always_ff @(posedge rise) begin
        if (accept) begin
            op_r   <= start_op;
            neg_r  <= operand_a[MD_WIDTH-1] ^ operand_b[MD_WIDTH-1];
            hi_r   <= '0;
            opnd_r <= ctrl_mult ? mag(operand_a) : mag(operand_b);
            lo_r   <= ctrl_mult ? mag(operand_b) : mag(operand_a);
        end else if (state == MD_RUN) begin
            hi_r <= step_hi;
            lo_r <= step_lo;
        end
    end

    always_ff @(posedge rise or negedge reset) begin
        if (!reset) begin
            result     <= '0;
            md_ovf     <= 1'b0;
            result_rdy <= 1'b0;
            busy       <= 1'b0;
        end else begin
            result_rdy <= (state_nxt == MD_DONE);
            busy       <= (state_nxt == MD_RUN);
            if (early_div0) begin
                result <= '0;
                md_ovf <= 1'b1;
            end else if (finish) begin
                result <= fixed[MD_WIDTH-1:0];
                md_ovf <= fixed[MD_WIDTH];
            end
        end
    end

endmodule

// File: doc/md_unit.md
# md_unit

Iterative signed multiply/divide unit that executes MULT and DIV for the execute stage. It produces the 32-bit result and the `md_ovf` exception flag that the X/M latch consumes. When `md_ovf` is set, the X/M latch rewrites the destination to r30 with a status code. `busy` feeds the hazard logic, which holds `stall_xm` while an operation is in flight.

## Interface
Parameters:
- `MD_WIDTH`, 32: operand and result width. Only 32 is supported.

Ports:
- `rise`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `operand_a`  in  32  dividend or multiplicand; two's complement.
- `operand_b`  in  32  divisor or multiplier; two's complement.
- `ctrl_mult`  in  1  one-cycle start pulse for multiply.
- `ctrl_div`  in  1  one-cycle start pulse for divide.
- `result`  out  32  registered result. Holds its value until the next DONE.
- `md_ovf`  out  1  registered exception flag for the last completed operation.
- `result_rdy`  out  1  one-cycle pulse marking that `result` and `md_ovf` are valid.
- `busy`  out  1  high while in RUN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE + start pulse → RUN:
  - latch operand magnitudes and signs;
  - latch operation type;
  - clear the iteration counter.
- `ctrl_mult` and `ctrl_div` in the same cycle: multiply wins.
- RUN performs one iteration per edge:
  - multiply: radix-2 shift-add on magnitudes into a 64-bit accumulator;
  - divide: restoring shift-subtract on magnitudes, 32-bit quotient and remainder.
- RUN → DONE on the edge where the counter equals 31, i.e. after 32 iterations. On that edge:
  - the sign fix-up is applied;
  - `result` and `md_ovf` are written.
- DONE → RUN if a start pulse is present; otherwise DONE → IDLE.
- Start pulses during RUN are ignored; no queuing.
- Multiply result and exception:
  - `result` = product[31:0];
  - `md_ovf` = 1 when product[63:32] is not the sign-extension of product[31].
- Divide result and exception:
  - quotient truncates toward zero; remainder is discarded;
  - divisor 0 → `result` = 0, `md_ovf` = 1;
  - 0x80000000 / -1 → `result` = 0x80000000, `md_ovf` = 1.
- Reset values, all applied immediately on reset low, mid-operation included:
  - state IDLE;
  - `result` = 0;
  - `md_ovf` = 0;
  - `result_rdy` = 0;
  - `busy` = 0;
  - counter = 0.
- Reset discards any in-flight operation without emitting a pulse.

## Timing
- Start pulse high in cycle 0 and sampled at the end of cycle 0.
- RUN in cycles 1–32; `busy` = 1 in exactly those cycles.
- DONE in cycle 33: `result_rdy` = 1 and the new `result`/`md_ovf` are visible. Latency is 33 cycles.
- A start pulse in cycle 33 puts RUN in cycle 34, giving a back-to-back throughput of 33 cycles per operation.
- `busy` is not asserted in cycle 0. The hazard unit covers cycle 0 from the decoded MULT/DIV.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MD_EARLY_DIV0_EN` defined:
  - a divide issued with `operand_b` = 0 goes IDLE → DONE directly;
  - `result` = 0, `md_ovf` = 1, `result_rdy` in cycle 1;
  - `busy` never asserts for that operation.
- Not defined: divide-by-zero runs the full 32 iterations and completes in cycle 33 with the same `result`/`md_ovf` values.

## Structure
- Package `md_pkg` holds:
  - state encodings `MD_IDLE`, `MD_RUN`, `MD_DONE`;
  - `MD_ITER` = 32;
  - op encoding `MD_OP_MULT`, `MD_OP_DIV`;
  - `MD_INT_MIN` = 32'h80000000.
- One sub-module: `md_iter_counter`. It is a 5-bit counter with synchronous clear, an enable, an async active-low reset, and a `last` flag when count == 31.
- FSM, datapath and sign fix-up live in `md_unit`.

## Test plan
- 7 × -6 at cycle 0 → `result` = 0xFFFFFFD6, `md_ovf` = 0, `result_rdy` high only in cycle 33, `busy` high in cycles 1–32.
- 0x00010000 × 0x00010000 → `result` = 0x00000000, `md_ovf` = 1.
- -100 / 7 → `result` = 0xFFFFFFF2, `md_ovf` = 0; then, with a start pulse in cycle 33, 0x80000000 / -1 → `result` = 0x80000000, `md_ovf` = 1 in cycle 66.
- 5 / 0 → `result` = 0, `md_ovf` = 1; `result_rdy` in cycle 33 without the macro, in cycle 1 with `MD_EARLY_DIV0_EN`.
- `ctrl_mult` and `ctrl_div` together with 6 and 3 → `result` = 18 (multiply wins). A `ctrl_div` pulse in cycle 5 is ignored: exactly one `result_rdy` pulse is seen in cycles 0–40.
- Start a multiply, pull `reset` low in cycle 10 → `busy`, `result_rdy`, `md_ovf` = 0 and `result` = 0 immediately; no pulse after release; a fresh 2 × 3 afterwards gives 6 after 33 cycles.
